core_ctrl_fsm: RTL and testbench
================================

// Module: core_ctrl_fsm
//
// PURPOSE
//   Multi-cycle control sequencer for the RV32I core. Walks each instruction
//   through fetch, decode, execute, memory and write-back. Drives the IR/PC/
//   register-file write strobes and the instruction/data memory request
//   handshakes from the instruction decoder's classification outputs.
//   Sits between the decoder and the PC, IR, regfile and bus glue.
//   Also keeps a retired-instruction counter and a bus timeout watchdog.
//
// PARAMETERS
//   CNT_W        32   width of instret counter (wraps modulo 2**CNT_W)
//   TIMEOUT_W    8    width of bus watchdog counter
//   MEM_TIMEOUT  255  max request cycles without ack before FAULT; 0 = disabled
//
// PORTS
//   clk        in   1      core clock
//   rst        in   1      asynchronous, active-high reset
//   run        in   1      start enable, sampled in BOOT
//   imem_req   out  1      instruction fetch request (held until imem_ack)
//   imem_ack   in   1      instruction data valid this cycle
//   ir_we      out  1      latch fetched instruction into IR
//   illegal    in   1      decoder: unknown opcode/funct
//   is_system  in   1      decoder: ECALL/EBREAK opcode
//   is_load    in   1      decoder: OP_LOAD
//   is_store   in   1      decoder: OP_STORE (mem_op == MEM_STORE)
//   reg_we_dec in   1      decoder: r_we == REG_WE
//   dmem_req   out  1      data access request (held until dmem_ack)
//   dmem_we    out  1      data access is a write (valid with dmem_req)
//   dmem_ack   in   1      data access complete this cycle
//   rf_we      out  1      register-file write strobe
//   pc_we      out  1      PC update strobe (PC mux selects next PC)
//   retire     out  1      one-cycle pulse per completed instruction
//   instret    out  CNT_W  retired-instruction count
//   halted     out  1      core stopped on ECALL/EBREAK (sticky)
//   fault      out  1      core stopped on illegal op or bus timeout (sticky)
//   state      out  3      current FSM state, for debug
//
// BEHAVIOUR
//   States (encoding):
//     BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
//   Reset:
//     - state=BOOT, instret=0, watchdog=0.
//     - Every output is 0 while rst is high and in BOOT.
//     - Strobes are decoded from registered state, so they drop
//       asynchronously on rst.
//   BOOT:   run=1 -> FETCH; else stay.
//   FETCH:
//     - imem_req=1.
//     - On imem_ack: ir_we=1 in the same cycle, -> DECODE.
//   DECODE: one cycle, no strobes. Priority:
//     illegal -> FAULT; is_system -> HALT; else -> EXEC.
//   EXEC:   one cycle (ALU settles). is_load|is_store -> MEM; else -> WB.
//   MEM:
//     - dmem_req=1; dmem_we=is_store.
//     - On dmem_ack with load -> WB.
//     - On dmem_ack with store: pc_we=1 and retire=1 that cycle, -> FETCH;
//       rf_we stays 0 (decoder r_we on stores is ignored).
//   WB:
//     - rf_we=reg_we_dec & ~is_store.
//     - pc_we=1, retire=1, -> FETCH.
//     - Branches pass through WB with reg_we_dec=0.
//   HALT:   halted=1. FAULT: fault=1. Both absorbing until rst; all strobes 0.
//   Latency (zero-wait acks):
//     - ALU/branch/jump: 4 cycles.
//     - Store: 4 cycles (FETCH, DECODE, EXEC, MEM).
//     - Load: 5 cycles.
//     - Each bus wait cycle adds 1.
//   Handshake:
//     - req is held high until the cycle ack is seen, then drops next cycle.
//     - ack while req=0 is ignored.
//     - ack in the first req cycle is legal.
//   Watchdog:
//     - Cleared on entry to FETCH/MEM; +1 each req cycle without ack.
//     - If MEM_TIMEOUT!=0 and MEM_TIMEOUT consecutive req cycles see no ack,
//       next state is FAULT and req drops.
//     - Ack in cycle MEM_TIMEOUT itself is still accepted.
//   instret:
//     - +1 on the clock edge ending a retire cycle; wraps to 0.
//     - HALT and FAULT never retire.
//   rst mid-operation: immediate return to BOOT; outstanding bus requests
//   are abandoned (bus glue must tolerate req dropping before ack).
//
// TESTING
//   1. run=1, ADDI, imem_ack in first req cycle
//      -> FETCH,DECODE,EXEC,WB repeating;
//         retire every 4th cycle; instret=3 after 12 cycles.
//   2. LW, dmem_ack after 3 req cycles
//      -> dmem_req high 3 cycles, dmem_we=0;
//         rf_we=1 only in WB; 7 cycles total.
//   3. SW, reg_we_dec=1, zero-wait ack
//      -> dmem_we=1, rf_we never 1;
//         pc_we/retire on ack cycle; 4 cycles.
//   4. MEM_TIMEOUT=4, imem_ack never
//      -> imem_req high exactly 4 cycles, then state=7, fault=1 sticky.
//   5. illegal=1 in DECODE -> FAULT, instret unchanged.
//      is_system=1 -> HALT, halted=1, no retire.
//   6. CNT_W=4: 16 retires -> instret=0.
//      rst pulse mid-MEM -> dmem_req=0 at once, state=0, instret=0.

Source files
------------

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I core: fetch/decode/execute/memory/write-back
// with a retired-instruction counter and a bus-timeout watchdog.
module core_ctrl_fsm #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_W   = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_we,
    input  logic             illegal,
    input  logic             is_system,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             reg_we_dec,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             rf_we,
    output logic             pc_we,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        FAULT  = 3'd7
    } state_e;

    localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);
    localparam bit                   WDOG_EN   = (MEM_TIMEOUT != 0);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     instret_q;
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
    logic                 timedOut;

    // True in the last permitted request cycle; an ack in that cycle still wins.
    assign timedOut = WDOG_EN && (wdog_q == WDOG_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= BOOT;
            instret_q <= '0;
            wdog_q    <= '0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        wdog_d   = '0;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        retire   = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;
        case (state_q)
            BOOT: begin
                if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = DECODE;
                end else if (timedOut) begin
                    state_d = FAULT;
                end else begin
                    wdog_d = wdog_q + TIMEOUT_W'(1);
                end
            end
            DECODE: begin
                if (illegal) begin
                    state_d = FAULT;
                end else if (is_system) begin
                    state_d = HALT;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = (is_load || is_store) ? MEM : WB;
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ack) begin
                    // Stores finish here; the decoder's register write is ignored.
                    if (is_store) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (timedOut) begin
                    state_d = FAULT;
                end else begin
                    wdog_d = wdog_q + TIMEOUT_W'(1);
                end
            end
            WB: begin
                rf_we   = reg_we_dec & ~is_store;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    assign instret = instret_q;
    assign state   = state_q;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Randomized self-checking bench for core_ctrl_fsm: each instruction is expanded into
// its expected per-cycle output trace from the sequencing rules, then replayed against the DUT.
module tb_core_ctrl_fsm;

    localparam int CNT_W       = 4;
    localparam int TIMEOUT_W   = 8;
    localparam int MEM_TIMEOUT = 4;

    logic             clk = 1'b0;
    logic             rst, run;
    logic             imem_req, imem_ack, ir_we;
    logic             illegal, is_system, is_load, is_store, reg_we_dec;
    logic             dmem_req, dmem_we, dmem_ack;
    logic             rf_we, pc_we, retire, halted, fault;
    logic [CNT_W-1:0] instret;
    logic [2:0]       state;

    int checks   = 0;
    int failures = 0;
    int expInstret;

    wire [11:0] obs = {state, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, retire, halted, fault};

    core_ctrl_fsm #(
        .CNT_W      (CNT_W),
        .TIMEOUT_W  (TIMEOUT_W),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .imem_req  (imem_req),
        .imem_ack  (imem_ack),
        .ir_we     (ir_we),
        .illegal   (illegal),
        .is_system (is_system),
        .is_load   (is_load),
        .is_store  (is_store),
        .reg_we_dec(reg_we_dec),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_ack  (dmem_ack),
        .rf_we     (rf_we),
        .pc_we     (pc_we),
        .retire    (retire),
        .instret   (instret),
        .halted    (halted),
        .fault     (fault),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ev(input int st, input bit ireq, input bit irwe, input bit dreq,
                                       input bit dwe, input bit rfwe, input bit pcwe, input bit ret,
                                       input bit hlt, input bit flt);
        logic [2:0] s;
        s = 3'(st);
        return {s, ireq, irwe, dreq, dwe, rfwe, pcwe, ret, hlt, flt};
    endfunction

    task automatic applyStimulus(input bit ia, input bit da, input logic [4:0] d);
        imem_ack = ia;
        dmem_ack = da;
        {illegal, is_system, is_load, is_store, reg_we_dec} = d;
    endtask

    // Checks one cycle's outputs and the counter, then advances to the next negedge.
    task automatic tick(input string tag, input logic [11:0] exp);
        #2;
        checkOutput(tag, 32'(obs), 32'(exp));
        checkOutput({tag, "_instret"}, 32'(instret), 32'(expInstret));
        if (exp[2]) expInstret = (expInstret + 1) % (1 << CNT_W);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        checkOutput("rst_outputs", 32'(obs), 32'd0);
        checkOutput("rst_instret", 32'(instret), 32'd0);
        expInstret = 0;
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        repeat (2) begin
            applyStimulus(1'($urandom), 1'($urandom), 5'($urandom));
            tick("boot_idle", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        run = 1'b1;
        applyStimulus(1'($urandom), 1'($urandom), 5'($urandom));
        tick("boot_run", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic terminal(input int st);
        repeat (3) begin
            applyStimulus(1'($urandom), 1'($urandom), 5'($urandom));
            if (st == 6) tick("halt", ev(6, 0, 0, 0, 0, 0, 0, 0, 1, 0));
            else         tick("fault", ev(7, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        end
        doReset();
    endtask

    // kind: 0 ALU, 1 branch, 2 load, 3 store, 4 illegal, 5 system.
    // fw/dw: wait cycles before ack; >= MEM_TIMEOUT means the ack never comes.
    task automatic runInstr(input int kind, input int fw, input int dw, input int rstAt = -1);
        logic [4:0] dec;
        bit         isL, isS, ack;
        case (kind)
            0:       dec = 5'b00001;
            1:       dec = 5'b00000;
            2:       dec = 5'b00101;
            3:       dec = 5'b00011;
            4:       dec = {1'b1, 4'($urandom)};
            default: dec = {2'b01, 3'($urandom)};
        endcase
        isL = dec[2];
        isS = dec[1];
        for (int i = 0; i < 64; i++) begin
            ack = (i == fw);
            applyStimulus(ack, 1'($urandom), 5'($urandom));
            tick("fetch", ev(1, 1, ack, 0, 0, 0, 0, 0, 0, 0));
            if (ack) break;
            if (i == MEM_TIMEOUT - 1) begin
                terminal(7);
                return;
            end
        end
        applyStimulus(1'($urandom), 1'($urandom), dec);
        tick("decode", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (dec[4]) begin
            terminal(7);
            return;
        end
        if (dec[3]) begin
            terminal(6);
            return;
        end
        applyStimulus(1'($urandom), 1'($urandom), dec);
        tick("exec", ev(3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (isL || isS) begin
            for (int i = 0; i < 64; i++) begin
                ack = (i == dw);
                applyStimulus(1'($urandom), ack, dec);
                if (i == rstAt) begin
                    #2;
                    checkOutput("mem_before_rst", 32'(obs), 32'(ev(4, 0, 0, 1, isS, 0, 0, 0, 0, 0)));
                    doReset();
                    return;
                end
                tick("mem", ev(4, 0, 0, 1, isS, 0, ack & isS, ack & isS, 0, 0));
                if (ack) begin
                    if (isS) return;
                    break;
                end
                if (i == MEM_TIMEOUT - 1) begin
                    terminal(7);
                    return;
                end
            end
        end
        applyStimulus(1'($urandom), 1'($urandom), dec);
        tick("wb", ev(5, 0, 0, 0, 0, dec[0] & ~isS, 1, 1, 0, 0));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout got=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int r, kind, fw, dw, rstAt;
        rst = 1'b1;
        run = 1'b0;
        applyStimulus(0, 0, 5'd0);
        expInstret = 0;
        doReset();

        repeat (3) runInstr(0, 0, 0);
        runInstr(2, 0, 2);
        runInstr(3, 0, 0);
        runInstr(1, 0, 0);
        repeat (16) runInstr(0, 0, 0);
        runInstr(0, 3, 0);
        runInstr(2, 3, 3);
        runInstr(3, 2, 3);
        runInstr(2, 1, 3, 1);
        runInstr(0, 9, 0);
        runInstr(2, 0, 9);
        runInstr(4, 0, 0);
        runInstr(5, 0, 0);

        repeat (250) begin
            r = $urandom_range(0, 99);
            if      (r < 35) kind = 0;
            else if (r < 50) kind = 1;
            else if (r < 70) kind = 2;
            else if (r < 88) kind = 3;
            else if (r < 94) kind = 4;
            else             kind = 5;
            fw    = ($urandom_range(0, 19) == 0) ? MEM_TIMEOUT : $urandom_range(0, MEM_TIMEOUT - 1);
            dw    = ($urandom_range(0, 19) == 0) ? MEM_TIMEOUT : $urandom_range(0, MEM_TIMEOUT - 1);
            rstAt = -1;
            if ((kind == 2 || kind == 3) && $urandom_range(0, 24) == 0) begin
                rstAt = $urandom_range(0, MEM_TIMEOUT - 2);
                dw    = MEM_TIMEOUT - 1;
            end
            runInstr(kind, fw, dw, rstAt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
